// File: rtl/ecp5pll_phase_pkg.sv
// Shared types and defaults for the ECP5 PLL dynamic phase-shift controller.
// Holds the FSM state encoding, PLL channel codes and the timer width helper.
package ecp5pll_phase_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_GAP,
        ST_LOAD,
        ST_DONE
    } state_e;

    localparam logic [1:0] CH_OS  = 2'd1;
    localparam logic [1:0] CH_OS2 = 2'd2;
    localparam logic [1:0] CH_OS3 = 2'd3;

    localparam int SETUP_CYC_DEF = 2;
    localparam int PULSE_CYC_DEF = 4;
    localparam int GAP_CYC_DEF   = 4;
    localparam int STEPS_W_DEF   = 8;

    // Bits needed to hold the largest (count - 1) loaded into the shared timer.
    function automatic int tmr_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/ecp5pll_phase_timer.sv
// Loadable down-counter with a zero flag; saturates at zero until reloaded.
// Timing of SETUP, PULSE, LOAD and GAP all comes from this one counter.
module ecp5pll_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ecp5pll_phase_ctrl.sv
// Sequences PLL phasesel/phasedir/phasestep/phaseloadreg for one request at a time.
// All PLL-facing outputs are registered; requests are only taken while idle.
module ecp5pll_phase_ctrl
    import ecp5pll_phase_pkg::*;
#(
    parameter int SETUP_CYC = SETUP_CYC_DEF,
    parameter int PULSE_CYC = PULSE_CYC_DEF,
    parameter int GAP_CYC   = GAP_CYC_DEF,
    parameter int STEPS_W   = STEPS_W_DEF,
    parameter int PH_W      = STEPS_W + 2
) (
    input  logic                   clk_i,
    input  logic                   reset_n,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [1:0]             req_chan_i,
    input  logic [STEPS_W-1:0]     req_steps_i,
    input  logic                   req_load_i,
    input  logic                   locked_i,
    output logic [1:0]             phasesel_o,
    output logic                   phasedir_o,
    output logic                   phasestep_o,
    output logic                   phaseloadreg_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic signed [PH_W-1:0] phase1_o,
    output logic signed [PH_W-1:0] phase2_o,
    output logic signed [PH_W-1:0] phase3_o
);

    localparam int TMR_W = tmr_width(SETUP_CYC, PULSE_CYC, GAP_CYC);
    localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(SETUP_CYC - 1);
    localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYC - 1);

    state_e                state_q, state_d;
    logic [1:0]            sel_q, sel_d;
    logic                  dir_q, dir_d;
    logic [STEPS_W-1:0]    rem_q, rem_d;
    logic                  ld_req_q, ld_req_d;
    logic signed [PH_W-1:0] ph1_q, ph1_d, ph2_q, ph2_d, ph3_q, ph3_d;
    logic                  step_q, step_d;
    logic                  ldreg_q, ldreg_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  ready_q, ready_d;

    logic                  tmr_load;
    logic [TMR_W-1:0]      tmr_val;
    logic                  tmr_zero;
    logic                  enter_pulse;
    logic signed [PH_W-1:0] delta;

    ecp5pll_phase_timer #(.W(TMR_W)) u_timer (
        .clk_i      (clk_i),
        .reset_n    (reset_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        dir_d       = dir_q;
        rem_d       = rem_q;
        ld_req_d    = ld_req_q;
        ph1_d       = ph1_q;
        ph2_d       = ph2_q;
        ph3_d       = ph3_q;
        err_d       = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        enter_pulse = 1'b0;
        delta       = dir_q ? {PH_W{1'b1}} : PH_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && ready_q) begin
                    if (req_chan_i == 2'd0) begin
                        err_d = 1'b1;
                    end else begin
                        sel_d    = req_chan_i;
                        dir_d    = req_steps_i[STEPS_W-1];
                        // Magnitude of the most negative count wraps to 2^(STEPS_W-1) unsigned.
                        rem_d    = req_steps_i[STEPS_W-1] ? (-req_steps_i) : req_steps_i;
                        ld_req_d = req_load_i;
                        if (req_steps_i == '0 && !req_load_i) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d  = ST_SETUP;
                            tmr_load = 1'b1;
                            tmr_val  = SETUP_LD;
                        end
                    end
                end
            end
            ST_SETUP: begin
                if (tmr_zero && locked_i) begin
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LD;
                    if (ld_req_q) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d     = ST_PULSE;
                        enter_pulse = 1'b1;
                    end
                end
            end
            ST_PULSE: begin
                if (tmr_zero) begin
                    state_d  = ST_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LD;
                end
            end
            ST_LOAD: begin
                if (tmr_zero) begin
                    state_d  = ST_GAP;
                    rem_d    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LD;
                end
            end
            ST_GAP: begin
                if (tmr_zero) begin
                    if (rem_q == '0) begin
                        state_d = ST_DONE;
                    end else if (locked_i) begin
                        state_d     = ST_PULSE;
                        enter_pulse = 1'b1;
                        tmr_load    = 1'b1;
                        tmr_val     = PULSE_LD;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enter_pulse) begin
            rem_d = rem_q - STEPS_W'(1);
            case (sel_q)
                CH_OS:   ph1_d = ph1_q + delta;
                CH_OS2:  ph2_d = ph2_q + delta;
                CH_OS3:  ph3_d = ph3_q + delta;
                default: ;
            endcase
        end

        step_d  = (state_d == ST_PULSE);
        ldreg_d = (state_d == ST_LOAD);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= CH_OS;
            dir_q    <= 1'b0;
            rem_q    <= '0;
            ld_req_q <= 1'b0;
            ph1_q    <= '0;
            ph2_q    <= '0;
            ph3_q    <= '0;
            step_q   <= 1'b0;
            ldreg_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            dir_q    <= dir_d;
            rem_q    <= rem_d;
            ld_req_q <= ld_req_d;
            ph1_q    <= ph1_d;
            ph2_q    <= ph2_d;
            ph3_q    <= ph3_d;
            step_q   <= step_d;
            ldreg_q  <= ldreg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
        end
    end

    assign req_ready_o    = ready_q;
    assign phasesel_o     = sel_q;
    assign phasedir_o     = dir_q;
    assign phasestep_o    = step_q;
    assign phaseloadreg_o = ldreg_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign phase1_o       = ph1_q;
    assign phase2_o       = ph2_q;
    assign phase3_o       = ph3_q;

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// Bench for ecp5pll_phase_ctrl: schedule-based model checked every cycle,
// plus literal per-request expectations (strobe offsets, counts, totals).
module tb_ecp5pll_phase_ctrl;

    localparam int S  = 2;
    localparam int P  = 4;
    localparam int G  = 4;
    localparam int SW = 8;
    localparam int PW = SW + 2;

    logic          clk_i = 1'b0;
    logic          reset_n = 1'b1;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [1:0]    req_chan_i = 2'd0;
    logic [SW-1:0] req_steps_i = '0;
    logic          req_load_i = 1'b0;
    logic          locked_i = 1'b1;
    logic [1:0]    phasesel_o;
    logic          phasedir_o;
    logic          phasestep_o;
    logic          phaseloadreg_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [PW-1:0] phase1_o;
    logic [PW-1:0] phase2_o;
    logic [PW-1:0] phase3_o;

    always #5 clk_i = ~clk_i;

    ecp5pll_phase_ctrl #(
        .SETUP_CYC(S), .PULSE_CYC(P), .GAP_CYC(G), .STEPS_W(SW), .PH_W(PW)
    ) dut (
        .clk_i          (clk_i),
        .reset_n        (reset_n),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_chan_i     (req_chan_i),
        .req_steps_i    (req_steps_i),
        .req_load_i     (req_load_i),
        .locked_i       (locked_i),
        .phasesel_o     (phasesel_o),
        .phasedir_o     (phasedir_o),
        .phasestep_o    (phasestep_o),
        .phaseloadreg_o (phaseloadreg_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .phase1_o       (phase1_o),
        .phase2_o       (phase2_o),
        .phase3_o       (phase3_o)
    );

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Request schedule: everything the outputs should do is derived from these.
    bit         sv = 1'b0;
    bit         m_err, m_load, m_dir;
    logic [1:0] m_ch = 2'd1;
    logic [1:0] prev_sel = 2'd1;
    bit         prev_dir = 1'b0;
    int         t0 = 0, n = 0, didx = 0, dly = 0, st0 = 0, done_c = 0;
    int         exp_acc [4] = '{default: 0};
    int         rel_c = 1 << 30;
    int         lk_lo = 0, lk_hi = 0;

    function automatic int wrap(input int v);
        int r;
        r = v & ((1 << PW) - 1);
        if (r >= (1 << (PW - 1))) r -= (1 << PW);
        return r;
    endfunction

    function automatic int start_of(input int i);
        return st0 + i * (P + G) + ((i >= didx) ? dly : 0);
    endfunction

    always @(negedge clk_i) begin : cmp
        int  c, cnt, s, e;
        bit  active, busy_e, step_e, ld_e, newv;
        c      = cyc;
        cnt    = 0;
        step_e = 1'b0;
        active = sv && !m_err;
        busy_e = active && c > t0 && c <= done_c;
        if (active && !m_load) begin
            for (int i = 0; i < n; i++) begin
                s = start_of(i);
                if (s <= c) begin
                    cnt++;
                    if (c < s + P) step_e = 1'b1;
                end
            end
        end
        ld_e = active && m_load && c >= st0 && c < st0 + P;
        newv = active && c > t0;
        chk("ready", int'(req_ready_o), int'(reset_n && c > rel_c && !busy_e));
        chk("busy", int'(busy_o), int'(busy_e));
        chk("done", int'(done_o), int'(active && c == done_c));
        chk("err", int'(err_o), int'(sv && m_err && c == t0 + 1));
        chk("phasestep", int'(phasestep_o), int'(step_e));
        chk("phaseloadreg", int'(phaseloadreg_o), int'(ld_e));
        chk("phasesel", int'(phasesel_o), int'(newv ? m_ch : prev_sel));
        chk("phasedir", int'(phasedir_o), int'(newv ? m_dir : prev_dir));
        for (int k = 1; k <= 3; k++) begin
            e = exp_acc[k];
            if (active && !m_load && int'(m_ch) == k) e += m_dir ? -cnt : cnt;
            e = wrap(e);
            case (k)
                1: chk("phase1", int'($signed(phase1_o)), e);
                2: chk("phase2", int'($signed(phase2_o)), e);
                default: chk("phase3", int'($signed(phase3_o)), e);
            endcase
        end
    end

    // Per-request observations used by the literal expectations.
    int rises [$];
    int ld_rises = 0, ld_hi = 0, done_cnt = 0, done_off = -1, err_cnt = 0;
    bit ps_prev = 1'b0, ld_prev = 1'b0;

    always @(negedge clk_i) begin
        if (phasestep_o && !ps_prev) rises.push_back(cyc - t0);
        if (phaseloadreg_o && !ld_prev) ld_rises++;
        if (phaseloadreg_o) ld_hi++;
        if (done_o) begin
            done_cnt++;
            done_off = cyc - t0;
        end
        if (err_o) err_cnt++;
        ps_prev = phasestep_o;
        ld_prev = phaseloadreg_o;
    end

    // Called just after a rising edge while the DUT is idle; returns one cycle later.
    task automatic start_req(input logic [1:0] ch, input int steps, input bit ld,
                             input int di, input int dl);
        if (sv && !m_err && !m_load) exp_acc[m_ch] = wrap(exp_acc[m_ch] + (m_dir ? -n : n));
        if (sv && !m_err) begin
            prev_sel = m_ch;
            prev_dir = m_dir;
        end
        t0     = cyc;
        m_ch   = ch;
        m_err  = (ch == 2'd0);
        m_load = ld;
        m_dir  = (steps < 0);
        n      = (steps < 0) ? -steps : steps;
        didx   = di;
        dly    = dl;
        st0    = t0 + 1 + S;
        if (m_err || (n == 0 && !ld)) done_c = t0 + 1;
        else if (ld) done_c = t0 + 1 + S + P + G;
        else done_c = t0 + 1 + S + n * (P + G) + ((di < n) ? dl : 0);
        sv = 1'b1;
        rises.delete();
        ld_rises = 0; ld_hi = 0; done_cnt = 0; done_off = -1; err_cnt = 0;
        req_valid_i = 1'b1;
        req_chan_i  = ch;
        req_steps_i = steps[SW-1:0];
        req_load_i  = ld;
        @(posedge clk_i); #2;
        req_valid_i = 1'b0;
    endtask

    // Junk requests are offered while busy; they must be ignored.
    task automatic wait_req();
        int guard;
        guard = 0;
        while (cyc <= done_c && guard < 3000) begin
            locked_i = !(cyc >= lk_lo && cyc < lk_hi);
            if (cyc < done_c && !m_err) begin
                req_valid_i = 1'b1;
                req_chan_i  = 2'($urandom_range(3));
                req_steps_i = SW'($urandom_range(255));
                req_load_i  = 1'($urandom_range(1));
            end else begin
                req_valid_i = 1'b0;
            end
            @(posedge clk_i); #2;
            guard++;
        end
        req_valid_i = 1'b0;
        locked_i    = 1'b1;
        if (guard >= 3000) chk("request_timeout", guard, 0);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk_i);
        #2;
        chk("rst_ready", int'(req_ready_o), 0);
        chk("rst_sel", int'(phasesel_o), 1);
        chk("rst_busy", int'(busy_o), 0);
        reset_n = 1'b1;
        rel_c   = cyc;
        @(posedge clk_i); #2;
        chk("rel_ready", int'(req_ready_o), 1);

        // chan 2, +3 steps
        start_req(2'd2, 3, 1'b0, 99, 0);
        wait_req();
        chk("c2_nrise", rises.size(), 3);
        chk("c2_rise0", rises[0], 3);
        chk("c2_rise1", rises[1], 11);
        chk("c2_rise2", rises[2], 19);
        chk("c2_done", done_off, 27);
        chk("c2_ph2", int'($signed(phase2_o)), 3);
        chk("c2_sel", int'(phasesel_o), 2);

        // chan 1, most negative count
        start_req(2'd1, -128, 1'b0, 999, 0);
        wait_req();
        chk("neg_nrise", rises.size(), 128);
        chk("neg_ph1", int'($signed(phase1_o)), -128);
        chk("neg_dir", int'(phasedir_o), 1);
        chk("neg_ndone", done_cnt, 1);

        // chan 3, load strobe only
        start_req(2'd3, 0, 1'b1, 99, 0);
        wait_req();
        chk("ld_nload", ld_rises, 1);
        chk("ld_hi", ld_hi, 4);
        chk("ld_nrise", rises.size(), 0);
        chk("ld_ph1", int'($signed(phase1_o)), -128);
        chk("ld_ph2", int'($signed(phase2_o)), 3);
        chk("ld_ph3", int'($signed(phase3_o)), 0);
        chk("ld_done", done_off, 11);

        // illegal channel
        start_req(2'd0, 5, 1'b0, 99, 0);
        wait_req();
        chk("ill_nerr", err_cnt, 1);
        chk("ill_nrise", rises.size(), 0);
        chk("ill_ndone", done_cnt, 0);
        chk("ill_ready", int'(req_ready_o), 1);

        // zero steps
        start_req(2'd2, 0, 1'b0, 99, 0);
        wait_req();
        chk("zero_done", done_off, 1);
        chk("zero_nrise", rises.size(), 0);

        // lock lost in the last cycle of the 2nd gap, back 10 cycles later
        start_req(2'd3, 4, 1'b0, 2, 10);
        lk_lo = t0 + 18;
        lk_hi = t0 + 28;
        wait_req();
        lk_lo = 0;
        lk_hi = 0;
        chk("lk_nrise", rises.size(), 4);
        chk("lk_rise1", rises[1], 11);
        chk("lk_rise2", rises[2], 29);
        chk("lk_rise3", rises[3], 37);
        chk("lk_done", done_off, 45);
        chk("lk_ph3", int'($signed(phase3_o)), 4);

        // further steps accumulate on channel 1
        start_req(2'd1, 5, 1'b0, 99, 0);
        wait_req();
        chk("acc_ph1", int'($signed(phase1_o)), -123);

        // reset in the middle of the first pulse
        start_req(2'd2, 4, 1'b0, 99, 0);
        while (cyc < t0 + 4) begin
            @(posedge clk_i); #2;
        end
        chk("mid_step_pre", int'(phasestep_o), 1);
        #1;
        reset_n  = 1'b0;
        sv       = 1'b0;
        exp_acc  = '{default: 0};
        prev_sel = 2'd1;
        prev_dir = 1'b0;
        #1;
        chk("mid_step", int'(phasestep_o), 0);
        chk("mid_ph2", int'($signed(phase2_o)), 0);
        chk("mid_ph1", int'($signed(phase1_o)), 0);
        chk("mid_sel", int'(phasesel_o), 1);
        chk("mid_ready", int'(req_ready_o), 0);
        repeat (2) @(posedge clk_i);
        #2;
        reset_n = 1'b1;
        rel_c   = cyc;
        @(posedge clk_i); #2;
        chk("mid_rel_ready", int'(req_ready_o), 1);

        start_req(2'd1, 2, 1'b0, 99, 0);
        wait_req();
        chk("post_ph1", int'($signed(phase1_o)), 2);
        chk("post_rise1", rises[1], 11);

        repeat (2) @(posedge clk_i);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ecp5pll_phase_ctrl.md
ECP5PLL_PHASE_CTRL -- requirements
Module: ecp5pll_phase_ctrl

Interface
REQ-001 Parameter SETUP_CYC, default 2: cycles phasesel_o/phasedir_o are held stable before the first strobe.
REQ-002 Parameter PULSE_CYC, default 4: high time of each phasestep_o or phaseloadreg_o strobe.
REQ-003 Parameter GAP_CYC, default 4: low time after each strobe.
REQ-004 Parameter STEPS_W, default 8: width of req_steps_i; PH_W = STEPS_W+2: width of each phase accumulator.
REQ-005 clk_i  in  1  single clock; all logic is on its rising edge.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 req_valid_i  in  1  request valid.
REQ-008 req_ready_o  out  1  request accepted on a cycle where valid and ready are both high.
REQ-009 req_chan_i  in  2  target PLL output: 1=CLKOS, 2=CLKOS2, 3=CLKOS3; 0 is illegal.
REQ-010 req_steps_i  in  STEPS_W  signed phase-step count; positive = dir 0, negative = dir 1.
REQ-011 req_load_i  in  1  1 = issue a phaseloadreg strobe instead of steps.
REQ-012 locked_i  in  1  PLL lock indication.
REQ-013 phasesel_o  out  2  to PLL phasesel (PLL-side encoding 1..3).
REQ-014 phasedir_o  out  1  to PLL phasedir.
REQ-015 phasestep_o  out  1  to PLL phasestep.
REQ-016 phaseloadreg_o  out  1  to PLL phaseloadreg.
REQ-017 busy_o  out  1  high whenever the FSM is not in IDLE.
REQ-018 done_o  out  1  one-cycle pulse when a request completes.
REQ-019 err_o  out  1  one-cycle pulse when a request is rejected.
REQ-020 phase1_o, phase2_o, phase3_o  out  PH_W each  signed running step totals per channel.

Function
REQ-021 FSM states SHALL be IDLE, SETUP, PULSE, GAP, LOAD, DONE.
REQ-022 req_ready_o SHALL be 1 only in IDLE.
REQ-023 Acceptance with req_chan_i=0 SHALL pulse err_o on the next cycle, stay in IDLE, and drive no strobe.
REQ-024 Acceptance with req_steps_i=0 and req_load_i=0 SHALL go directly to DONE, with no strobe.
REQ-025 A valid accepted request (cycle T) SHALL latch chan, direction, and |steps| into an unsigned STEPS_W count; -2^(STEPS_W-1) SHALL yield 2^(STEPS_W-1) steps.
REQ-026 Outputs SHALL change as follows from cycle T+1:
- phasesel_o/phasedir_o take the new values.
- The FSM holds in SETUP for SETUP_CYC cycles.
REQ-027 SETUP->PULSE (or ->LOAD when req_load_i was set) SHALL occur only when the SETUP count is exhausted and locked_i=1; otherwise the FSM holds in SETUP.
REQ-028 PULSE SHALL drive phasestep_o=1 for PULSE_CYC cycles, then enter GAP.
REQ-029 GAP SHALL drive phasestep_o=0 for GAP_CYC cycles; the next state SHALL be:
- PULSE, when steps remain and locked_i=1;
- GAP (hold), when steps remain and locked_i=0;
- DONE, when no steps remain.
REQ-030 LOAD SHALL drive phaseloadreg_o=1 for PULSE_CYC cycles, then enter GAP with zero remaining steps.
REQ-031 The selected channel accumulator SHALL add +1 (dir 0) or -1 (dir 1) on each PULSE entry, with two's-complement wrap; LOAD SHALL leave all accumulators unchanged.
REQ-032 DONE SHALL last one cycle with done_o=1, then return to IDLE.
REQ-033 Timing for an N-step request accepted at T (locked_i held 1):
- first phasestep_o rise at T+1+SETUP_CYC;
- done_o at T+1+SETUP_CYC+N*(PULSE_CYC+GAP_CYC).
REQ-034 phasesel_o and phasedir_o SHALL be stable from SETUP until DONE; phasestep_o and phaseloadreg_o SHALL never be high together.
REQ-035 Request inputs SHALL be ignored while req_ready_o=0.

Reset
REQ-036 reset_n=0 SHALL asynchronously force the following:
- state=IDLE;
- phasesel_o=1, phasedir_o=0, phasestep_o=0, phaseloadreg_o=0;
- busy_o=0, done_o=0, err_o=0;
- all accumulators=0;
- req_ready_o=0 while reset_n=0, and 1 on the first clock after release.
REQ-037 Reset during PULSE or LOAD SHALL terminate the strobe immediately; no partial accumulator update shall persist.

Structure
REQ-038 Package ecp5pll_phase_pkg SHALL hold the state enum, channel constants (CH_OS=1, CH_OS2=2, CH_OS3=3), and parameter defaults.
REQ-039 Sub-module ecp5pll_phase_timer SHALL provide a loadable down-counter with a zero flag, shared by SETUP, PULSE, and GAP timing.
REQ-040 The implementation SHALL be fully synchronous apart from the asynchronous reset, with no combinational path from inputs to the PLL-facing outputs.

Verification
REQ-041 chan=2, steps=+3, locked=1, accepted at T: phasesel=2, dir=0; phasestep rises at T+3, T+11, T+19; done_o at T+27; phase2_o=3.
REQ-042 chan=1, steps=-128 (STEPS_W=8): exactly 128 strobes with dir=1; phase1_o=-128.
REQ-043 chan=3, load=1: exactly one phaseloadreg pulse of 4 cycles; phasestep stays 0; accumulators unchanged; done_o follows.
REQ-044 chan=0: err_o pulses once; no strobe; ready stays 1. steps=0: done_o at T+1 with no strobe.
REQ-045 locked_i dropped during the 2nd GAP of a 4-step request and restored 10 cycles later: 3rd strobe delayed 10 cycles; total strobe count is 4.
REQ-046 reset_n asserted mid-PULSE: phasestep_o=0 asynchronously; all outputs at reset values; ready=1 on the first clock after release.
